// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal shift register: hold / shift right / shift left /
//   parallel load under a mode select, serial in and out at both ends, plus an
//   auto-shift burst engine (one start command -> N shifts, with busy/done).
//
// Parameters
//   WIDTH   register width in bits (>= 2)
//   CNT_W   width of the burst count input and remaining-shift counter
//
// Ports
//   clock    rising-edge clock
//   reset    synchronous, active-high reset
//   mode     manual op: 00 hold, 01 shift right, 10 shift left, 11 load
//   enable   qualifies manual ops (0 = hold)
//   data     parallel load value
//   sin_r    serial bit entering the MSB on a right shift
//   sin_l    serial bit entering the LSB on a left shift
//   start    burst request, sampled in IDLE only
//   count    number of shifts in the burst
//   dir      burst direction: 0 right, 1 left
//   dataout  register contents
//   sout_r   dataout[0]        (combinational from the register)
//   sout_l   dataout[WIDTH-1]  (combinational from the register)
//   busy     high while a burst is in progress
//   done     one-cycle pulse after a burst (or a zero-count start) completes
//
// Build option
//   SHIFT_ROTATE_EN  when defined, every shift rotates and sin_r/sin_l are
//                    ignored; otherwise shifts take the serial inputs.
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             dir,
    output logic [WIDTH-1:0] dataout,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic             r_state;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_remaining;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;

    logic             w_fill_r;
    logic             w_fill_l;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;

`ifdef SHIFT_ROTATE_EN
    // Rotate: the bit falling off one end re-enters at the other.
    assign w_fill_r = r_data[0];
    assign w_fill_l = r_data[WIDTH-1];
`else
    assign w_fill_r = sin_r;
    assign w_fill_l = sin_l;
`endif

    // Shared by manual ops and the burst engine so both builds shift alike.
    assign w_shr = {w_fill_r, r_data[WIDTH-1:1]};
    assign w_shl = {r_data[WIDTH-2:0], w_fill_l};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_remaining <= '0;
            r_dir       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // No shift on the start edge; a zero count completes
                        // immediately without ever raising busy.
                        if (count != '0) begin
                            r_remaining <= count;
                            r_dir       <= dir;
                            r_busy      <= 1'b1;
                            r_state     <= ST_BURST;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end else if (enable) begin
                        case (mode)
                            MODE_HOLD: r_data <= r_data;
                            MODE_SHR:  r_data <= w_shr;
                            MODE_SHL:  r_data <= w_shl;
                            MODE_LOAD: r_data <= data;
                            default:   r_data <= r_data;
                        endcase
                    end
                end
                ST_BURST: begin
                    r_data      <= r_dir ? w_shl : w_shr;
                    r_remaining <= r_remaining - 1'b1;
                    // This edge performs the last shift of the burst.
                    if (r_remaining == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dataout = r_data;
    assign sout_r  = r_data[0];
    assign sout_l  = r_data[WIDTH-1];
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       mode;
    logic             enable;
    logic [WIDTH-1:0] data;
    logic             sin_r, sin_l, start, dir;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dataout;
    logic             sout_r, sout_l, busy, done;

    always #5 clock = ~clock;

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .mode(mode), .enable(enable),
        .data(data), .sin_r(sin_r), .sin_l(sin_l), .start(start),
        .count(count), .dir(dir), .dataout(dataout), .sout_r(sout_r),
        .sout_l(sout_l), .busy(busy), .done(done)
    );

    typedef struct {
        logic             rst;
        logic [1:0]       mode;
        logic             en;
        logic [WIDTH-1:0] data;
        logic             sr, sl, st;
        logic [CNT_W-1:0] cnt;
        logic             dir;
        logic [WIDTH-1:0] exp_q;
        logic             exp_b, exp_d;
        string            name;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             b, d;
        string            name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic [1:0] m, input logic e,
                       input logic [WIDTH-1:0] dt, input logic sr, input logic sl,
                       input logic st, input logic [CNT_W-1:0] c, input logic d,
                       input logic [WIDTH-1:0] q, input logic b, input logic dn,
                       input string nm);
        vec_t v;
        v.rst = r; v.mode = m; v.en = e; v.data = dt; v.sr = sr; v.sl = sl;
        v.st = st; v.cnt = c; v.dir = d; v.exp_q = q; v.exp_b = b; v.exp_d = dn;
        v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkq(input string nm, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, clock, then pop and compare.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clock);
        reset = v.rst; mode = v.mode; enable = v.en; data = v.data;
        sin_r = v.sr; sin_l = v.sl; start = v.st; count = v.cnt; dir = v.dir;
        e.q = v.exp_q; e.b = v.exp_b; e.d = v.exp_d; e.name = v.name;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = sb.pop_front();
            chkq({e.name, ".dataout"}, dataout, e.q);
            chk1({e.name, ".busy"},    busy,    e.b);
            chk1({e.name, ".done"},    done,    e.d);
            chk1({e.name, ".sout_r"},  sout_r,  e.q[0]);
            chk1({e.name, ".sout_l"},  sout_l,  e.q[WIDTH-1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mode = 2'b00; enable = 1'b0; data = '0; sin_r = 1'b0;
        sin_l = 1'b0; start = 1'b0; count = '0; dir = 1'b0;

        //   rst mode en data sr sl st cnt dir  exp   b  d   name
        // Reset holds off a pending load, then the load goes through.
        add(1, 2'b11, 1, 4'hF, 0, 0, 0, 3'd0, 0, 4'h0, 0, 0, "rst0");
        add(1, 2'b11, 1, 4'hF, 0, 0, 0, 3'd0, 0, 4'h0, 0, 0, "rst1");
        add(0, 2'b11, 1, 4'hF, 0, 0, 0, 3'd0, 0, 4'hF, 0, 0, "rst_release");
`ifndef SHIFT_ROTATE_EN
        // Load / hold / enable gating.
        add(0, 2'b11, 1, 4'hA, 0, 0, 0, 3'd0, 0, 4'hA, 0, 0, "load_A");
        add(0, 2'b00, 1, 4'h5, 0, 0, 0, 3'd0, 0, 4'hA, 0, 0, "hold0");
        add(0, 2'b00, 1, 4'h5, 0, 0, 0, 3'd0, 0, 4'hA, 0, 0, "hold1");
        add(0, 2'b00, 1, 4'h5, 0, 0, 0, 3'd0, 0, 4'hA, 0, 0, "hold2");
        add(0, 2'b11, 0, 4'h5, 0, 0, 0, 3'd0, 0, 4'hA, 0, 0, "en_off");
        // Manual shifts.
        add(0, 2'b01, 1, 4'h0, 1, 0, 0, 3'd0, 0, 4'hD, 0, 0, "shr");
        add(0, 2'b10, 1, 4'h0, 1, 0, 0, 3'd0, 0, 4'hA, 0, 0, "shl");
        // Left burst of 3 with loads (and a stray start) ignored meanwhile.
        add(0, 2'b11, 1, 4'h1, 0, 0, 0, 3'd0, 0, 4'h1, 0, 0, "load_1");
        add(0, 2'b11, 1, 4'hF, 0, 0, 1, 3'd3, 1, 4'h1, 1, 0, "bl_start");
        add(0, 2'b11, 1, 4'hF, 0, 0, 1, 3'd0, 0, 4'h2, 1, 0, "bl_s1");
        add(0, 2'b11, 1, 4'hF, 0, 0, 0, 3'd0, 0, 4'h4, 1, 0, "bl_s2");
        add(0, 2'b11, 1, 4'hF, 0, 0, 0, 3'd0, 0, 4'h8, 0, 1, "bl_s3");
        add(0, 2'b00, 1, 4'hF, 0, 0, 0, 3'd0, 0, 4'h8, 0, 0, "bl_after");
        // Zero count: done pulse, no busy, no change.
        add(0, 2'b11, 1, 4'hF, 0, 0, 1, 3'd0, 0, 4'h8, 0, 1, "zero_cnt");
        // Start accepted during a done cycle: 1-shift right burst.
        add(0, 2'b11, 1, 4'hF, 1, 0, 1, 3'd1, 0, 4'h8, 1, 0, "start_in_done");
        add(0, 2'b00, 1, 4'hF, 1, 0, 0, 3'd0, 0, 4'hC, 0, 1, "b1_s1");
        add(0, 2'b00, 1, 4'hF, 1, 0, 0, 3'd0, 0, 4'hC, 0, 0, "b1_after");
        // Count > WIDTH, right, live sin_r sequence 1,0,1,1,0.
        add(0, 2'b11, 1, 4'h0, 0, 0, 0, 3'd0, 0, 4'h0, 0, 0, "load_0");
        add(0, 2'b00, 0, 4'h0, 0, 0, 1, 3'd5, 0, 4'h0, 1, 0, "br_start");
        add(0, 2'b00, 0, 4'h0, 1, 0, 0, 3'd0, 0, 4'h8, 1, 0, "br_s1");
        add(0, 2'b00, 0, 4'h0, 0, 0, 0, 3'd0, 0, 4'h4, 1, 0, "br_s2");
        add(0, 2'b00, 0, 4'h0, 1, 0, 0, 3'd0, 0, 4'hA, 1, 0, "br_s3");
        add(0, 2'b00, 0, 4'h0, 1, 0, 0, 3'd0, 0, 4'hD, 1, 0, "br_s4");
        add(0, 2'b00, 0, 4'h0, 0, 0, 0, 3'd0, 0, 4'h6, 0, 1, "br_s5");
        // Abort: count 4, reset after 2 shifts, no done pulse afterwards.
        add(0, 2'b11, 1, 4'hF, 0, 0, 0, 3'd0, 0, 4'hF, 0, 0, "load_F");
        add(0, 2'b00, 0, 4'h0, 0, 0, 1, 3'd4, 0, 4'hF, 1, 0, "ab_start");
        add(0, 2'b00, 0, 4'h0, 0, 0, 0, 3'd0, 0, 4'h7, 1, 0, "ab_s1");
        add(0, 2'b00, 0, 4'h0, 0, 0, 0, 3'd0, 0, 4'h3, 1, 0, "ab_s2");
        add(1, 2'b00, 0, 4'h0, 0, 0, 0, 3'd0, 0, 4'h0, 0, 0, "ab_reset");
        add(0, 2'b00, 0, 4'h0, 0, 0, 0, 3'd0, 0, 4'h0, 0, 0, "ab_after0");
        add(0, 2'b00, 0, 4'h0, 0, 0, 0, 3'd0, 0, 4'h0, 0, 0, "ab_after1");
`else
        // Rotate build: serial inputs are ignored.
        add(0, 2'b11, 1, 4'h9, 1, 1, 0, 3'd0, 0, 4'h9, 0, 0, "load_9");
        add(0, 2'b01, 1, 4'h0, 0, 1, 0, 3'd0, 0, 4'hC, 0, 0, "rot_r");
        add(0, 2'b11, 1, 4'h0, 1, 1, 1, 3'd4, 1, 4'hC, 1, 0, "rl_start");
        add(0, 2'b11, 1, 4'h0, 0, 0, 0, 3'd0, 0, 4'h9, 1, 0, "rl_s1");
        add(0, 2'b11, 1, 4'h0, 0, 0, 0, 3'd0, 0, 4'h3, 1, 0, "rl_s2");
        add(0, 2'b11, 1, 4'h0, 0, 0, 0, 3'd0, 0, 4'h6, 1, 0, "rl_s3");
        add(0, 2'b11, 1, 4'h0, 0, 0, 0, 3'd0, 0, 4'hC, 0, 1, "rl_s4");
        add(0, 2'b10, 1, 4'h0, 0, 0, 0, 3'd0, 0, 4'h9, 0, 0, "rot_l");
`endif

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
